// File: rtl/sysbus_arb_if.sv
// System bus arbitration interface: requester-side handshake and the
// arbiter's grant/status outputs, bundled so the arbiter and its bench
// share one definition.
interface sysbus_arb_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] done;
  logic            hold;
  logic [NREQ-1:0] gnt;
  logic            busy;
  logic [2:0]      owner;
  logic            alarm;
  logic [2:0]      alarm_src;

  // Requester / cycle-control side
  modport master (
    output req, done, hold,
    input  gnt, busy, owner, alarm, alarm_src
  );

  // Arbiter side
  modport slave (
    input  req, done, hold,
    output gnt, busy, owner, alarm, alarm_src
  );
endinterface

// File: rtl/sysbus_arb.sv
// System bus arbiter: shares the memory/IO bus between the CPU P-M
// sequencer (requester 0) and the I/O channels (1..NREQ-1). One grant at a
// time, held until the owner pulses done; a watchdog releases a silent
// transfer and latches a sticky alarm.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | bus free; pick a winner when hold=0 and any request is up
// S_GRANT | register the one-hot grant for the chosen winner
// S_XFER  | owner holds the bus; watchdog counts until done or timeout
// S_REL   | grant dropped; advance round-robin pointer
module sysbus_arb #(
  parameter int          NREQ     = 4,
  parameter bit          CPU_PRIO = 1'b1,
  parameter int unsigned TMO      = 63
) (
  input  logic         clk_i,
  input  logic         clm_i,
  sysbus_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_XFER  = 2'd2,
    S_REL   = 2'd3
  } state_e;

  localparam logic [7:0] TMO_C  = 8'(TMO);
  localparam logic [3:0] NREQ_C = 4'(NREQ);

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [2:0]      owner_q, owner_d;
  logic [2:0]      winner_q, winner_d;
  logic [2:0]      rr_q, rr_d;
  logic            prio_q, prio_d;
  logic            alarm_q, alarm_d;
  logic [2:0]      alarm_src_q, alarm_src_d;
  logic [7:0]      wd_q, wd_d;

  logic [7:0]      req_pad;
  logic [7:0]      done_pad;
  logic [7:0]      wd_inc;
  logic [3:0]      own_inc;
  logic [2:0]      rr_nxt;
  logic [3:0]      sum4;
  logic [2:0]      pick_idx;
  logic            pick_found;
  logic            pick_prio;
  logic [NREQ-1:0] winner_oh;

  // Zero-extend the request/done vectors so a 3-bit index is always in range.
  assign req_pad  = 8'(bus.req);
  assign done_pad = 8'(bus.done);

  // Watchdog saturates at 8'hFF rather than wrapping back to zero.
  assign wd_inc  = (wd_q == 8'hFF) ? wd_q : wd_q + 8'd1;

  assign own_inc = {1'b0, owner_q} + 4'd1;
  assign rr_nxt  = (own_inc == NREQ_C) ? 3'd0 : own_inc[2:0];

  // Winner selection: CPU override first, otherwise first request at or after rr pointer.
  always_comb begin
    pick_idx   = 3'd0;
    pick_found = 1'b0;
    pick_prio  = 1'b0;
    sum4       = 4'd0;
    if (CPU_PRIO && bus.req[0]) begin
      pick_found = 1'b1;
      pick_prio  = 1'b1;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        sum4 = {1'b0, rr_q} + 4'(k);
        if (sum4 >= NREQ_C) begin
          sum4 = sum4 - NREQ_C;
        end
        if (!pick_found && req_pad[sum4[2:0]]) begin
          pick_found = 1'b1;
          pick_idx   = sum4[2:0];
        end
      end
    end
  end

  // One-hot decode of the latched winner.
  always_comb begin
    winner_oh = '0;
    for (int k = 0; k < NREQ; k++) begin
      winner_oh[k] = (winner_q == 3'(k));
    end
  end

  // Next-state and output logic.
  // A CPU win by priority override does not move the rr pointer, so the
  // channel rotation resumes where it left off once the CPU is served.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    winner_d    = winner_q;
    rr_d        = rr_q;
    prio_d      = prio_q;
    alarm_d     = alarm_q;
    alarm_src_d = alarm_src_q;
    wd_d        = wd_q;
    case (state_q)
      S_IDLE: begin
        if (!bus.hold && pick_found) begin
          winner_d = pick_idx;
          prio_d   = pick_prio;
          state_d  = S_GRANT;
        end
      end
      S_GRANT: begin
        gnt_d   = winner_oh;
        owner_d = winner_q;
        wd_d    = 8'd0;
        state_d = S_XFER;
      end
      S_XFER: begin
        wd_d = wd_inc;
        if (done_pad[owner_q]) begin
          gnt_d   = '0;
          state_d = S_REL;
        end else if (wd_inc == TMO_C) begin
          gnt_d       = '0;
          alarm_d     = 1'b1;
          alarm_src_d = owner_q;
          state_d     = S_REL;
        end
      end
      S_REL: begin
        if (!prio_q) begin
          rr_d = rr_nxt;
        end
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; machine clear drops the grant at once.
  always_ff @(posedge clk_i or posedge clm_i) begin
    if (clm_i) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      owner_q     <= 3'd0;
      winner_q    <= 3'd0;
      rr_q        <= 3'd0;
      prio_q      <= 1'b0;
      alarm_q     <= 1'b0;
      alarm_src_q <= 3'd0;
      wd_q        <= 8'd0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      winner_q    <= winner_d;
      rr_q        <= rr_d;
      prio_q      <= prio_d;
      alarm_q     <= alarm_d;
      alarm_src_q <= alarm_src_d;
      wd_q        <= wd_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = |gnt_q;
  assign bus.owner     = owner_q;
  assign bus.alarm     = alarm_q;
  assign bus.alarm_src = alarm_src_q;

endmodule

// File: tb/tb_sysbus_arb.sv
// Bench for sysbus_arb: dut_a runs with CPU priority, dut_b with pure
// round-robin; both share stimulus, each is checked in its own scenarios.
module tb_sysbus_arb;

  logic       clk = 1'b0;
  logic       clm = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] done = '0;
  logic       hold = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sysbus_arb_if #(.NREQ(4)) bus_a ();
  sysbus_arb_if #(.NREQ(4)) bus_b ();

  assign bus_a.req  = req;
  assign bus_a.done = done;
  assign bus_a.hold = hold;
  assign bus_b.req  = req;
  assign bus_b.done = done;
  assign bus_b.hold = hold;

  sysbus_arb #(.NREQ(4), .CPU_PRIO(1'b1), .TMO(63)) dut_a (
    .clk_i (clk),
    .clm_i (clm),
    .bus   (bus_a)
  );

  sysbus_arb #(.NREQ(4), .CPU_PRIO(1'b0), .TMO(63)) dut_b (
    .clk_i (clk),
    .clm_i (clm),
    .bus   (bus_b)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] done;
    logic       hold;
    logic [3:0] gnt;
    logic       busy;
    logic [2:0] owner;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [3:0] rq, input logic [3:0] dn, input logic hd,
                     input logic [3:0] g, input logic b, input logic [2:0] ow);
    vec_t v;
    v.req = rq; v.done = dn; v.hold = hd;
    v.gnt = g;  v.busy = b;  v.owner = ow;
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] cur_gnt(input bit sel);
    return sel ? bus_b.gnt : bus_a.gnt;
  endfunction

  task automatic do_reset();
    clm = 1'b1; req = '0; done = '0; hold = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clm = 1'b0;
  endtask

  task automatic wait_gnt(input bit sel, input logic [3:0] exp, input string nm);
    int n;
    n = 0;
    while (cur_gnt(sel) == 4'd0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(nm, int'(cur_gnt(sel)), int'(exp));
  endtask

  task automatic pulse_done(input logic [3:0] d);
    done = d;
    @(negedge clk);
    done = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int order[5];
    int low;
    order = '{0, 1, 2, 3, 0};

    //   req      done     hold  gnt      busy  owner
    add(4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0);  // IDLE decides
    add(4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0);  // GRANT
    add(4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 3'd0);  // gnt 2 ticks after req
    add(4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 3'd0);
    add(4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 3'd0);
    add(4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1, 3'd0);  // done[0]
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0);  // REL
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0);
    add(4'b0011, 4'b0000, 1'b1, 4'b0000, 1'b0, 3'd0);  // hold blocks
    add(4'b0011, 4'b0000, 1'b1, 4'b0000, 1'b0, 3'd0);
    add(4'b0011, 4'b0000, 1'b1, 4'b0000, 1'b0, 3'd0);
    add(4'b0011, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0);  // hold released
    add(4'b0011, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0);
    add(4'b0011, 4'b0001, 1'b0, 4'b0001, 1'b1, 3'd0);  // CPU wins
    add(4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0);
    add(4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0);
    add(4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0);
    add(4'b0000, 4'b0001, 1'b1, 4'b0010, 1'b1, 3'd1);  // req dropped, stray done
    add(4'b0000, 4'b0010, 1'b1, 4'b0010, 1'b1, 3'd1);  // hold does not stop XFER
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd1);
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd1);

    // Reset values on both instances
    @(negedge clk);
    check("rst_gnt_a",   int'(bus_a.gnt), 0);
    check("rst_busy_a",  int'(bus_a.busy), 0);
    check("rst_owner_a", int'(bus_a.owner), 0);
    check("rst_alarm_a", int'(bus_a.alarm), 0);
    check("rst_src_a",   int'(bus_a.alarm_src), 0);
    check("rst_gnt_b",   int'(bus_b.gnt), 0);
    @(negedge clk);
    clm = 1'b0;

    // Table: single request, hold, priority, stray done, req drop
    foreach (vq[i]) begin
      @(negedge clk);
      check($sformatf("vec%0d_gnt", i),   int'(bus_a.gnt),   int'(vq[i].gnt));
      check($sformatf("vec%0d_busy", i),  int'(bus_a.busy),  int'(vq[i].busy));
      check($sformatf("vec%0d_owner", i), int'(bus_a.owner), int'(vq[i].owner));
      check($sformatf("vec%0d_alarm", i), int'(bus_a.alarm), 0);
      req  = vq[i].req;
      done = vq[i].done;
      hold = vq[i].hold;
    end

    // CPU priority does not disturb the channel rotation
    do_reset();
    req = 4'b1110;
    wait_gnt(1'b0, 4'b0010, "prio_first");
    pulse_done(4'b0010);
    wait_gnt(1'b0, 4'b0100, "prio_second");
    check("prio_owner2", int'(bus_a.owner), 2);
    req = 4'b1111;
    pulse_done(4'b0100);
    wait_gnt(1'b0, 4'b0001, "prio_cpu");
    req = 4'b1110;
    pulse_done(4'b0001);
    wait_gnt(1'b0, 4'b1000, "prio_rr3");
    req = 4'b0000;
    pulse_done(4'b1000);

    // Watchdog timeout on owner 2
    do_reset();
    req = 4'b0100;
    wait_gnt(1'b0, 4'b0100, "tmo_gnt");
    repeat (62) @(negedge clk);
    check("tmo62_alarm", int'(bus_a.alarm), 0);
    check("tmo62_gnt",   int'(bus_a.gnt), 4);
    @(negedge clk);
    check("tmo_alarm", int'(bus_a.alarm), 1);
    check("tmo_src",   int'(bus_a.alarm_src), 2);
    check("tmo_gnt0",  int'(bus_a.gnt), 0);
    check("tmo_busy0", int'(bus_a.busy), 0);
    wait_gnt(1'b0, 4'b0100, "tmo_regrant");
    check("tmo_sticky", int'(bus_a.alarm), 1);
    req = 4'b0000;
    pulse_done(4'b0100);

    // Machine clear in the middle of a transfer
    req = 4'b0010;
    wait_gnt(1'b0, 4'b0010, "clm_gnt");
    #2 clm = 1'b1;
    #1;
    check("clm_gnt",   int'(bus_a.gnt), 0);
    check("clm_busy",  int'(bus_a.busy), 0);
    check("clm_alarm", int'(bus_a.alarm), 0);
    check("clm_src",   int'(bus_a.alarm_src), 0);
    check("clm_owner", int'(bus_a.owner), 0);
    @(negedge clk);
    clm = 1'b0;
    req = 4'b0001;
    @(negedge clk);
    check("clm_idle_dec", int'(bus_a.gnt), 0);
    @(negedge clk);
    check("clm_idle_gnt", int'(bus_a.gnt), 1);
    req = 4'b0000;
    pulse_done(4'b0001);

    // done on the very tick the watchdog hits the limit: no alarm
    req = 4'b0100;
    wait_gnt(1'b0, 4'b0100, "tie_gnt");
    repeat (62) @(negedge clk);
    done = 4'b0100;
    @(negedge clk);
    done = '0;
    req  = '0;
    check("tie_gnt0",  int'(bus_a.gnt), 0);
    check("tie_alarm", int'(bus_a.alarm), 0);
    repeat (3) @(negedge clk);
    check("tie_alarm_later", int'(bus_a.alarm), 0);

    // Pure round-robin on dut_b: order 0,1,2,3,0 with 3-tick gaps
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin
        wait_gnt(1'b1, 4'b0001, "rr_first");
      end else begin
        low = 0;
        while (bus_b.gnt == 4'd0 && low < 10) begin
          low++;
          @(negedge clk);
        end
        check($sformatf("rr_gap%0d", k), low, 3);
      end
      check($sformatf("rr_order%0d", k), int'(bus_b.gnt), 1 << order[k]);
      repeat (3) @(negedge clk);
      done = 4'(1 << order[k]);
      @(negedge clk);
      done = '0;
      check($sformatf("rr_rel%0d", k), int'(bus_b.gnt), 0);
    end
    req = '0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
